// File: rtl/buffer_pkg.sv
// rtl/buffer_pkg.sv - shared types for the line read-data buffer
package buffer_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_FILL_WAIT,
        ST_RESP
    } state_e;

    typedef struct packed {
        logic [31:0] addr;
        size_e       size;
        logic        sgn;
    } req_t;

    localparam int REQ_W = $bits(req_t);

    // Misaligned half/word accesses and the reserved size are rejected without a fill.
    function automatic logic req_bad(input logic [31:0] addr, input size_e size);
        logic bad;
        bad = 1'b1;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr[0];
            SZ_WORD: bad = (addr[1:0] != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/req_fifo.sv
// rtl/req_fifo.sv - request queue, power-of-two depth, head always visible
module req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 35
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    output logic                     full,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/line_rdata_buffer.sv
// rtl/line_rdata_buffer.sv - single-line read buffer: queue, lookup, fill, extract
module line_rdata_buffer #(
    parameter int LINE_BITS = 256,
    parameter int WORD_BITS = 32,
    parameter int DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [31:0]          req_addr,
    input  logic [1:0]           req_size,
    input  logic                 req_signed,
    output logic                 fill_req,
    output logic [31:0]          fill_addr,
    input  logic                 fill_valid,
    input  logic [LINE_BITS-1:0] fill_data,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [WORD_BITS-1:0] resp_rdata,
    output logic                 resp_err
);

    import buffer_pkg::*;

    localparam int OFF_BITS = $clog2(LINE_BITS / 8);
    localparam int TAG_W    = 32 - OFF_BITS;
    localparam int CNT_W    = $clog2(DEPTH) + 1;
    localparam int EXT_W    = (WORD_BITS > 32) ? WORD_BITS : 32;

    state_e                 state_q, state_d;
    logic                   line_vld_q, line_vld_d;
    logic [TAG_W-1:0]       line_tag_q, line_tag_d;
    logic [LINE_BITS-1:0]   line_data_q, line_data_d;
    logic                   fill_req_q, fill_req_d;
    logic [31:0]            fill_addr_q, fill_addr_d;
    logic [WORD_BITS-1:0]   resp_rdata_q, resp_rdata_d;
    logic                   resp_err_q, resp_err_d;

    req_t                   new_req, head;
    logic                   fifo_full, fifo_empty, push, pop;
    logic [CNT_W-1:0]       fifo_cnt;

    logic [TAG_W-1:0]       head_tag;
    logic [OFF_BITS-1:0]    head_off;
    logic                   hit, bad, sign_bit;
    logic [EXT_W-1:0]       lane;
    logic [WORD_BITS-1:0]   raw, low_mask, ext;

    always_comb begin
        new_req.addr = req_addr;
        new_req.size = size_e'(req_size);
        new_req.sgn  = req_signed;
    end

    assign req_ready = !fifo_full;
    assign push      = req_valid && req_ready;

    req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REQ_W)
    ) u_req_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (new_req),
        .full      (fifo_full),
        .pop       (pop),
        .head      (head),
        .empty     (fifo_empty),
        .count     (fifo_cnt)
    );

    // Lookup and data extraction for the request at the queue head.
    always_comb begin
        head_tag = head.addr[31:OFF_BITS];
        head_off = head.addr[OFF_BITS-1:0];
        hit      = line_vld_q && (line_tag_q == head_tag);
        bad      = req_bad(head.addr, head.size);
        lane     = EXT_W'(line_data_q >> {head_off, 3'b000});
        raw      = lane[WORD_BITS-1:0];
        case (head.size)
            SZ_BYTE: begin
                low_mask = WORD_BITS'(32'h0000_00ff);
                sign_bit = lane[7];
            end
            SZ_HALF: begin
                low_mask = WORD_BITS'(32'h0000_ffff);
                sign_bit = lane[15];
            end
            default: begin
                low_mask = WORD_BITS'(32'hffff_ffff);
                sign_bit = lane[31];
            end
        endcase
        ext = (raw & low_mask) | ({WORD_BITS{head.sgn & sign_bit}} & ~low_mask);
    end

    always_comb begin
        state_d      = state_q;
        line_vld_d   = line_vld_q;
        line_tag_d   = line_tag_q;
        line_data_d  = line_data_q;
        fill_req_d   = 1'b0;
        fill_addr_d  = fill_addr_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        pop          = 1'b0;

        // A delivered line always belongs to the last requested address.
        if (fill_valid) begin
            line_vld_d  = 1'b1;
            line_tag_d  = fill_addr_q[31:OFF_BITS];
            line_data_d = fill_data;
        end

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) state_d = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                if (fifo_empty) begin
                    state_d = ST_IDLE;
                end else if (bad || hit) begin
                    resp_rdata_d = bad ? '0 : ext;
                    resp_err_d   = bad;
                    state_d      = ST_RESP;
                end else begin
                    fill_req_d  = 1'b1;
                    fill_addr_d = {head_tag, {OFF_BITS{1'b0}}};
                    state_d     = ST_FILL_WAIT;
                end
            end
            ST_FILL_WAIT: begin
                if (fill_valid) state_d = ST_LOOKUP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    pop     = 1'b1;
                    state_d = ((fifo_cnt > CNT_W'(1)) || push) ? ST_LOOKUP : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            line_vld_q   <= 1'b0;
            line_tag_q   <= '0;
            line_data_q  <= '0;
            fill_req_q   <= 1'b0;
            fill_addr_q  <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            line_vld_q   <= line_vld_d;
            line_tag_q   <= line_tag_d;
            line_data_q  <= line_data_d;
            fill_req_q   <= fill_req_d;
            fill_addr_q  <= fill_addr_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign fill_req   = fill_req_q;
    assign fill_addr  = fill_addr_q;
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_line_rdata_buffer.sv
// tb/tb_line_rdata_buffer.sv - directed and randomized bench against a memory-level model
module tb_line_rdata_buffer;

    localparam int LB = 256;
    localparam int WB = 32;
    localparam int DP = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [31:0]   req_addr = '0;
    logic [1:0]    req_size = '0;
    logic          req_signed = 1'b0;
    logic          fill_req;
    logic [31:0]   fill_addr;
    logic          fill_valid = 1'b0;
    logic [LB-1:0] fill_data = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [WB-1:0] resp_rdata;
    logic          resp_err;

    always #5 clk = ~clk;

    line_rdata_buffer #(.LINE_BITS(LB), .WORD_BITS(WB), .DEPTH(DP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_signed (req_signed),
        .fill_req   (fill_req),
        .fill_addr  (fill_addr),
        .fill_valid (fill_valid),
        .fill_data  (fill_data),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct { bit [31:0] addr; bit [1:0] size; bit sgn; } mreq_t;
    typedef struct { bit [31:0] addr; int due; } pfill_t;

    mreq_t      exp_q[$];
    pfill_t     pf_q[$];
    logic [7:0] ov [bit [31:0]];

    bit          mvalid = 0;
    bit [31:0]   mbase = 0;
    int          fills_for_head = 0;
    int          fill_total = 0;
    int          resp_total = 0;
    int          cyc = 0;
    int          fill_delay = 2;
    bit          rand_fill = 0;
    bit          rand_ready = 0;
    bit          ready_level = 1;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;
    logic [31:0] last_fill_addr = '0;

    function automatic bit [31:0] base_of(input bit [31:0] a);
        return a & 32'hffff_ffe0;
    endfunction

    function automatic logic [7:0] mem_byte(input bit [31:0] a);
        if (ov.exists(a)) return ov[a];
        return 8'(a[7:0] * 8'd37) ^ a[15:8] ^ 8'h5a;
    endfunction

    function automatic logic [LB-1:0] line_of(input bit [31:0] b);
        logic [LB-1:0] d;
        d = '0;
        for (int k = 0; k < LB / 8; k++) d[8*k +: 8] = mem_byte(b + 32'(k));
        return d;
    endfunction

    function automatic bit model_err(input mreq_t r);
        return (r.size == 2'd3) || (r.size == 2'd1 && r.addr[0]) || (r.size == 2'd2 && r.addr[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] model_data(input mreq_t r);
        logic [63:0] v, m;
        int n;
        if (model_err(r)) return 32'h0;
        n = 1 << r.size;
        v = '0;
        for (int k = 0; k < n; k++) v = v | (64'(mem_byte(r.addr + 32'(k))) << (8 * k));
        m = (64'h1 << (8 * n)) - 64'h1;
        if (r.sgn && v[8*n-1]) v = v | ~m;
        return v[31:0];
    endfunction

    // Memory side: deliver each requested line after its delay.
    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        fill_valid = 1'b0;
        if (pf_q.size() > 0 && pf_q[0].due <= cyc) begin
            fill_valid = 1'b1;
            fill_data  = line_of(pf_q[0].addr);
            void'(pf_q.pop_front());
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        resp_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_level;
    end

    // Monitor: fill requests and response handshakes against the model.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (fill_req) begin
                pfill_t p;
                fill_total++;
                fills_for_head++;
                last_fill_addr = fill_addr;
                if (exp_q.size() == 0) begin
                    check_eq("fill_without_request", 1, 0);
                    p.addr = base_of(fill_addr);
                end else begin
                    check_eq("fill_addr", fill_addr, base_of(exp_q[0].addr));
                    p.addr = base_of(exp_q[0].addr);
                end
                p.due = cyc + (rand_fill ? int'($urandom_range(1, 4)) : fill_delay);
                pf_q.push_back(p);
            end
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_resp", 1, 0);
                end else begin
                    mreq_t r;
                    bit need;
                    r = exp_q.pop_front();
                    need = !model_err(r) && !(mvalid && mbase == base_of(r.addr));
                    check_eq("resp_rdata", resp_rdata, model_data(r));
                    check_eq("resp_err", resp_err, model_err(r));
                    check_eq("fill_count", fills_for_head, need);
                    if (need) begin
                        mvalid = 1;
                        mbase  = base_of(r.addr);
                    end
                    fills_for_head = 0;
                    last_rdata = resp_rdata;
                    last_err   = resp_err;
                    resp_total++;
                end
            end
        end
    end

    task automatic send(input bit [31:0] a, input bit [1:0] s, input bit g);
        mreq_t r;
        int w;
        w = 0;
        @(posedge clk);
        #1;
        req_valid = 1'b1; req_addr = a; req_size = s; req_signed = g;
        @(negedge clk);
        while (!req_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) begin
            check_eq("req_accept_timeout", 0, 1);
        end else begin
            r.addr = a; r.size = s; r.sgn = g;
            exp_q.push_back(r);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() > 0 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        check_eq("drain_pending", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_req_ready", req_ready, 1);
        check_eq("rst_fill_req", fill_req, 0);
        check_eq("rst_fill_addr", fill_addr, 0);
        check_eq("rst_resp_valid", resp_valid, 0);
        check_eq("rst_resp_rdata", resp_rdata, 0);
        check_eq("rst_resp_err", resp_err, 0);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req_valid = 1'b0;
        #1;
        check_reset_outputs();
        exp_q.delete();
        pf_q.delete();
        fills_for_head = 0;
        mvalid = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int f0, r0, lat, w;
        bit [31:0] bases [4];
        bit [31:0] a;
        bit [1:0]  s;

        ov[32'h1004] = 8'hef; ov[32'h1005] = 8'hbe; ov[32'h1006] = 8'had; ov[32'h1007] = 8'hde;
        ov[32'h2005] = 8'h80;
        bases[0] = 32'h1000; bases[1] = 32'h2000; bases[2] = 32'h3020; bases[3] = 32'h1020;

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;

        // cold miss, line delivered 3 cycles after fill_req
        fill_delay = 3;
        f0 = fill_total;
        send(32'h1004, 2'd2, 1'b0);
        drain();
        check_eq("cold_fill_addr", last_fill_addr, 32'h1000);
        check_eq("cold_rdata", last_rdata, 32'hdead_beef);
        check_eq("cold_err", last_err, 0);
        check_eq("cold_fill_cnt", fill_total - f0, 1);

        // signed and unsigned bytes from a held line
        fill_delay = 2;
        send(32'h2000, 2'd2, 1'b0);
        drain();
        f0 = fill_total;
        send(32'h2005, 2'd0, 1'b1);
        drain();
        check_eq("byte_signed", last_rdata, 32'hffff_ff80);
        send(32'h2005, 2'd0, 1'b0);
        drain();
        check_eq("byte_unsigned", last_rdata, 32'h0000_0080);
        check_eq("byte_no_fill", fill_total - f0, 0);

        // misaligned word
        f0 = fill_total;
        send(32'h1002, 2'd2, 1'b0);
        drain();
        check_eq("misalign_err", last_err, 1);
        check_eq("misalign_rdata", last_rdata, 0);
        check_eq("misalign_no_fill", fill_total - f0, 0);

        // hit latency from acceptance in IDLE
        send(32'h2010, 2'd2, 1'b0);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid && lat < 20);
        check_eq("hit_latency", lat - 1, 2);
        drain();

        // backpressure with a full queue
        ready_level = 0;
        repeat (2) @(posedge clk);
        r0 = resp_total;
        send(32'h2000, 2'd2, 1'b0);
        send(32'h2002, 2'd1, 1'b1);
        send(32'h2005, 2'd0, 1'b1);
        send(32'h201c, 2'd2, 1'b0);
        @(negedge clk);
        check_eq("bp_req_ready_full", req_ready, 0);
        check_eq("bp_no_resp_yet", resp_total - r0, 0);
        fork
            begin
                repeat (6) @(posedge clk);
                ready_level = 1;
            end
        join_none
        send(32'h2011, 2'd0, 1'b0);
        drain();
        check_eq("bp_resp_cnt", resp_total - r0, 5);

        // line switch A -> B -> A
        f0 = fill_total;
        send(32'h2004, 2'd2, 1'b0);
        drain();
        check_eq("switch_hit_a", fill_total - f0, 0);
        send(32'h1008, 2'd2, 1'b1);
        drain();
        check_eq("switch_fill_b", fill_total - f0, 1);
        send(32'h2008, 2'd1, 1'b1);
        drain();
        check_eq("switch_refill_a", fill_total - f0, 2);

        // reset while waiting for a fill
        fill_delay = 8;
        f0 = fill_total;
        r0 = resp_total;
        send(32'h3000, 2'd2, 1'b0);
        w = 0;
        while (fill_total == f0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check_eq("rst_fill_seen", fill_total - f0, 1);
        pulse_reset();
        repeat (20) @(negedge clk);
        check_eq("rst_no_resp", resp_total - r0, 0);
        check_eq("rst_resp_valid_after", resp_valid, 0);
        check_eq("rst_req_ready_after", req_ready, 1);
        check_eq("rst_no_refill", fill_total - f0, 1);
        fill_delay = 2;

        // randomized traffic
        rand_ready = 1;
        rand_fill  = 1;
        for (int i = 0; i < 80; i++) begin
            a = bases[$urandom_range(0, 3)] + 32'($urandom_range(0, 31));
            s = 2'($urandom_range(0, 3));
            if (s != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~((32'h1 << s) - 32'h1);
            send(a, s, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
